// File: rtl/cmp_result_queue_if.sv
// Handshake bundle between Compare10, the result queue and its consumer.
// The slave modport is the queue's view; the master modport is the producer/consumer side.
interface cmp_result_queue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_fcn;
    logic             in_o;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_res;
    logic [3:0]       out_fcn;
    logic [TAG_W-1:0] out_tag;
    logic             out_ill;

    modport slave (
        input  in_valid, in_fcn, in_o, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_fcn, out_tag, out_ill
    );

    modport master (
        output in_valid, in_fcn, in_o, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_fcn, out_tag, out_ill
    );
endinterface

// File: rtl/cmp_result_queue.sv
// Result FIFO behind Compare10: tags each result, flags illegal function codes.
// Optional result statistics are enabled by defining CMP_RESULT_QUEUE_STATS_EN.
module cmp_result_queue #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cmp_result_queue_if.slave        bus,
    input  logic                     clr_err,
    output logic                     err_ill,
    output logic [$clog2(DEPTH):0]   level
`ifdef CMP_RESULT_QUEUE_STATS_EN
    ,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         cnt_true,
    output logic [CNT_W-1:0]         cnt_false
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Compare10 function encodings
    localparam logic [3:0] CMP10_ULT = 4'h0;
    localparam logic [3:0] CMP10_ULE = 4'h1;
    localparam logic [3:0] CMP10_SLT = 4'h2;
    localparam logic [3:0] CMP10_SLE = 4'h3;
    localparam logic [3:0] CMP10_EQU = 4'h4;
    localparam logic [3:0] CMP10_UGE = 4'h5;
    localparam logic [3:0] CMP10_UGT = 4'h6;
    localparam logic [3:0] CMP10_SGE = 4'h7;
    localparam logic [3:0] CMP10_SGT = 4'h8;
    localparam logic [3:0] CMP10_NEQ = 4'h9;

    typedef struct packed {
        logic             ill;
        logic             res;
        logic [3:0]       fcn;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_err;

    logic w_legal;
    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    ent_t w_ent;
    ent_t w_head;

    always_comb begin
        w_legal = 1'b0;
        case (bus.in_fcn)
            CMP10_ULT, CMP10_ULE, CMP10_SLT, CMP10_SLE, CMP10_EQU,
            CMP10_UGE, CMP10_UGT, CMP10_SGE, CMP10_SGT, CMP10_NEQ: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // Ready/valid come straight from the occupancy register, never from out_ready.
    assign w_in_ready  = (r_level != LW'(DEPTH));
    assign w_out_valid = (r_level != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    assign w_ent.ill = ~w_legal;
    assign w_ent.res = w_legal & bus.in_o;
    assign w_ent.fcn = bus.in_fcn;
    assign w_ent.tag = bus.in_tag;

    always_ff @(posedge clk) begin
        if (rst_n && w_push)
            r_mem[r_wptr] <= w_ent;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A fresh illegal push outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_push && !w_legal)
            r_err <= 1'b1;
        else if (clr_err)
            r_err <= 1'b0;
    end

    assign w_head = r_mem[r_rptr];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_res   = w_out_valid & w_head.res;
    assign bus.out_ill   = w_out_valid & w_head.ill;
    assign bus.out_fcn   = w_out_valid ? w_head.fcn : 4'h0;
    assign bus.out_tag   = w_out_valid ? w_head.tag : '0;
    assign err_ill       = r_err;
    assign level         = r_level;

`ifdef CMP_RESULT_QUEUE_STATS_EN
    logic [CNT_W-1:0] r_cnt_true;
    logic [CNT_W-1:0] r_cnt_false;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            r_cnt_true  <= '0;
            r_cnt_false <= '0;
        end else if (w_push && w_legal) begin
            if (bus.in_o) begin
                if (r_cnt_true != '1)  r_cnt_true  <= r_cnt_true + 1'b1;
            end else begin
                if (r_cnt_false != '1) r_cnt_false <= r_cnt_false + 1'b1;
            end
        end
    end

    assign cnt_true  = r_cnt_true;
    assign cnt_false = r_cnt_false;
`endif
endmodule

// File: tb/tb_cmp_result_queue.sv
// Directed bench for cmp_result_queue with a queue scoreboard of expected entries.
// Define CMP_RESULT_QUEUE_STATS_EN to also exercise the statistics counters (CNT_W=2).
module tb_cmp_result_queue;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
`ifdef CMP_RESULT_QUEUE_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             ill;
        logic             res;
        logic [3:0]       fcn;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_err;
    logic          err_ill;
    logic [LW-1:0] level;
`ifdef CMP_RESULT_QUEUE_STATS_EN
    logic             clr_stats;
    logic [CNT_W-1:0] cnt_true;
    logic [CNT_W-1:0] cnt_false;
    int               m_ct;
    int               m_cf;
`endif

    cmp_result_queue_if #(.TAG_W(TAG_W)) bus ();

    cmp_result_queue #(.TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .clr_err  (clr_err),
        .err_ill  (err_ill),
        .level    (level)
`ifdef CMP_RESULT_QUEUE_STATS_EN
        ,
        .clr_stats(clr_stats),
        .cnt_true (cnt_true),
        .cnt_false(cnt_false)
`endif
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   m_level;
    bit   m_err;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] f, input logic o,
                       input logic [TAG_W-1:0] t, input logic ordy);
        bus.in_valid  = v;
        bus.in_fcn    = f;
        bus.in_o      = o;
        bus.in_tag    = t;
        bus.out_ready = ordy;
    endtask

    // Check the current registered state against the model, then advance one edge.
    task automatic tick();
        bit   push, pop, ill;
        exp_t e;
        exp_t h;
        chk("in_ready", 32'(bus.in_ready), 32'(m_level != DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(m_level != 0));
        chk("level", 32'(level), 32'(m_level));
        chk("err_ill", 32'(err_ill), 32'(m_err));
`ifdef CMP_RESULT_QUEUE_STATS_EN
        chk("cnt_true", 32'(cnt_true), 32'(m_ct));
        chk("cnt_false", 32'(cnt_false), 32'(m_cf));
`endif
        h = '0;
        if (m_level != 0 && sb.size() > 0) h = sb[0];
        chk("out_res", 32'(bus.out_res), 32'(h.res));
        chk("out_ill", 32'(bus.out_ill), 32'(h.ill));
        chk("out_fcn", 32'(bus.out_fcn), 32'(h.fcn));
        chk("out_tag", 32'(bus.out_tag), 32'(h.tag));

        ill   = !(bus.in_fcn inside {[4'h0:4'h9]});
        e.ill = ill;
        e.res = ill ? 1'b0 : bus.in_o;
        e.fcn = bus.in_fcn;
        e.tag = bus.in_tag;
        push  = bus.in_valid && (m_level != DEPTH);
        pop   = bus.out_ready && (m_level != 0);
        if (!rst_n) begin
            sb.delete();
            m_level = 0;
            m_err   = 0;
`ifdef CMP_RESULT_QUEUE_STATS_EN
            m_ct = 0;
            m_cf = 0;
`endif
        end else begin
            if (pop && sb.size() > 0) void'(sb.pop_front());
            if (push) sb.push_back(e);
            m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
            if (push && ill) m_err = 1;
            else if (clr_err) m_err = 0;
`ifdef CMP_RESULT_QUEUE_STATS_EN
            if (clr_stats) begin
                m_ct = 0;
                m_cf = 0;
            end else if (push && !ill) begin
                if (bus.in_o) m_ct = (m_ct == (1 << CNT_W) - 1) ? m_ct : m_ct + 1;
                else          m_cf = (m_cf == (1 << CNT_W) - 1) ? m_cf : m_cf + 1;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst_n   = 1'b0;
        clr_err = 1'b0;
`ifdef CMP_RESULT_QUEUE_STATS_EN
        clr_stats = 1'b0;
        m_ct = 0; m_cf = 0;
`endif
        drv(0, 4'h0, 0, '0, 0);
        @(posedge clk);
        #1;
        sb.delete();
        m_level = 0;
        m_err   = 0;
        tick();                                  // reset state under reset
        rst_n = 1'b1;
        tick();

        // single entry: ULT, o=1, tag 3
        drv(1, 4'h0, 1, 4'h3, 0); tick();
        drv(0, 4'h0, 0, '0, 1);   tick();
        chk("t1_empty", 32'(level), 32'd0);
        tick();

        // fill, overflow attempt, drain in order
        for (int i = 1; i <= 4; i++) begin
            drv(1, 4'(i % 10), i[0], 4'(i), 0); tick();
        end
        chk("t2_full_level", 32'(level), 32'd4);
        chk("t2_full_rdy", 32'(bus.in_ready), 32'd0);
        drv(1, 4'h4, 1, 4'h5, 0); tick();
        drv(0, 4'h0, 0, '0, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t2_drained", 32'(bus.out_valid), 32'd0);

        // sustained push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drv(1, 4'(9 - i), i[1], 4'(i), 1); tick();
        end
        chk("t3_level", 32'(level), 32'd1);
        drv(0, 4'h0, 0, '0, 1); tick();
        tick();

        // illegal code, set-vs-clear priority, then clear
        drv(1, 4'hF, 1, 4'hA, 1); tick();
        clr_err = 1'b1;
        drv(1, 4'hF, 1, 4'hB, 1); tick();
        drv(0, 4'h0, 0, '0, 1);   tick();
        clr_err = 1'b0;
        tick();
        chk("t4_cleared", 32'(err_ill), 32'd0);

        // reset mid-operation with three queued entries
        drv(1, 4'h2, 1, 4'h1, 0); tick();
        drv(1, 4'hC, 1, 4'h2, 0); tick();
        drv(1, 4'h5, 0, 4'h3, 0); tick();
        chk("t5_level3", 32'(level), 32'd3);
        rst_n = 1'b0;
        drv(1, 4'h1, 1, 4'h4, 1); tick();
        rst_n = 1'b1;
        drv(0, 4'h0, 0, '0, 0);   tick();
        chk("t5_rst_level", 32'(level), 32'd0);
        chk("t5_rst_rdy", 32'(bus.in_ready), 32'd1);

`ifdef CMP_RESULT_QUEUE_STATS_EN
        for (int i = 0; i < 3; i++) begin drv(1, 4'h4, 1, 4'(i), 1); tick(); end
        for (int i = 0; i < 2; i++) begin drv(1, 4'h9, 0, 4'(i), 1); tick(); end
        drv(1, 4'hE, 1, 4'h7, 1); tick();
        drv(0, 4'h0, 0, '0, 1);   tick();
        chk("t6_true", 32'(cnt_true), 32'd3);
        chk("t6_false", 32'(cnt_false), 32'd2);
        clr_stats = 1'b1; tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 5; i++) begin drv(1, 4'h6, 1, 4'(i), 1); tick(); end
        drv(0, 4'h0, 0, '0, 1); tick();
        chk("t6_sat", 32'(cnt_true), 32'd3);
        clr_stats = 1'b1; tick();
        clr_stats = 1'b0; tick();
        chk("t6_clr_true", 32'(cnt_true), 32'd0);
        chk("t6_clr_false", 32'(cnt_false), 32'd0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
